// File: rtl/cap_trunc_pipe.sv
// Capability field precision reducer with one registered valid/ready stage.
// Floor/ceil rounding of a parametrised field, tag invalidation on ceil overflow, saturating stats.
module cap_trunc_pipe #(
    parameter int CAP_W      = 129,
    parameter int FIELD_LSB  = 0,
    parameter int FIELD_W    = 32,
    parameter int TRUNC_BITS = 10,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CAP_W-1:0] in_cap,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CAP_W-1:0] out_cap,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] lossy_count,
    output logic [CNT_W-1:0] tag_clear_count
);

    localparam int HI_W = FIELD_W - TRUNC_BITS;

    if ((TRUNC_BITS < 1) || (TRUNC_BITS > FIELD_W - 1) || (FIELD_LSB + FIELD_W > CAP_W - 1)) begin : g_bad_cfg
        $error("cap_trunc_pipe: illegal field/truncation configuration");
    end

    logic [FIELD_W-1:0] field_s;
    logic               low_nz_s;
    logic [HI_W:0]      hi_inc_s;
    logic               ceil_ovf_s;
    logic [FIELD_W-1:0] floor_s;
    logic [FIELD_W-1:0] ceil_s;
    logic [FIELD_W-1:0] new_field_s;
    logic               new_tag_s;
    logic [CAP_W-1:0]   next_cap_s;
    logic               lossy_ev_s;
    logic               tag_clr_ev_s;
    logic               accept_s;

    logic               out_valid_r;
    logic [CAP_W-1:0]   out_cap_r;
    logic [CNT_W-1:0]   lossy_cnt_r;
    logic [CNT_W-1:0]   tag_clr_cnt_r;

    // Rounding datapath: derive the rewritten field, tag and statistics events.
    always_comb begin
        field_s     = in_cap[FIELD_LSB +: FIELD_W];
        low_nz_s    = |field_s[TRUNC_BITS-1:0];
        floor_s     = {field_s[FIELD_W-1:TRUNC_BITS], {TRUNC_BITS{1'b0}}};
        hi_inc_s    = {1'b0, field_s[FIELD_W-1:TRUNC_BITS]} + {{HI_W{1'b0}}, 1'b1};
        ceil_s      = {hi_inc_s[HI_W-1:0], {TRUNC_BITS{1'b0}}};
        ceil_ovf_s  = 1'b0;
        new_field_s = field_s;
        new_tag_s   = in_cap[CAP_W-1];
        lossy_ev_s  = 1'b0;
        case (in_mode)
            2'b01: begin
                new_field_s = floor_s;
                lossy_ev_s  = low_nz_s;
            end
            2'b10: begin
                lossy_ev_s = low_nz_s;
                if (!low_nz_s) begin
                    new_field_s = field_s;
                end else if (hi_inc_s[HI_W]) begin
                    // Rounded bound no longer fits: keep floor value and invalidate.
                    ceil_ovf_s  = 1'b1;
                    new_field_s = floor_s;
                    new_tag_s   = 1'b0;
                end else begin
                    new_field_s = ceil_s;
                end
            end
            default: begin
                new_field_s = field_s;
            end
        endcase
        tag_clr_ev_s = ceil_ovf_s & in_cap[CAP_W-1];
        next_cap_s                         = in_cap;
        next_cap_s[FIELD_LSB +: FIELD_W]   = new_field_s;
        next_cap_s[CAP_W-1]                = new_tag_s;
    end

    assign in_ready = !out_valid_r || out_ready;
    assign accept_s = in_valid && in_ready;

    // Output stage: load on accept, drop valid when drained, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_cap_r   <= {CAP_W{1'b0}};
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_cap_r   <= next_cap_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Saturating statistics counters; clear wins over a coincident event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lossy_cnt_r   <= {CNT_W{1'b0}};
            tag_clr_cnt_r <= {CNT_W{1'b0}};
        end else if (clr_stats) begin
            lossy_cnt_r   <= {CNT_W{1'b0}};
            tag_clr_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (accept_s && lossy_ev_s && (lossy_cnt_r != {CNT_W{1'b1}})) begin
                lossy_cnt_r <= lossy_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (accept_s && tag_clr_ev_s && (tag_clr_cnt_r != {CNT_W{1'b1}})) begin
                tag_clr_cnt_r <= tag_clr_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_valid       = out_valid_r;
    assign out_cap         = out_cap_r;
    assign lossy_count     = lossy_cnt_r;
    assign tag_clear_count = tag_clr_cnt_r;

endmodule

// File: tb/tb_cap_trunc_pipe.sv
// Directed self-checking bench for cap_trunc_pipe (default field layout, 4-bit counters).
module tb_cap_trunc_pipe;

    localparam int CAP_W  = 129;
    localparam int CNT_W  = 4;
    localparam int NVEC   = 10;
    localparam int CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [CAP_W-1:0] in_cap;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [CAP_W-1:0] out_cap;
    logic             clr_stats;
    logic [CNT_W-1:0] lossy_count;
    logic [CNT_W-1:0] tag_clear_count;

    always #5 clk = ~clk;

    cap_trunc_pipe #(
        .CAP_W(CAP_W), .FIELD_LSB(0), .FIELD_W(32), .TRUNC_BITS(10), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_cap(in_cap), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_cap(out_cap),
        .clr_stats(clr_stats), .lossy_count(lossy_count), .tag_clear_count(tag_clear_count)
    );

    typedef struct {
        logic        tag;
        logic [95:0] upper;
        logic [31:0] low;
        logic [1:0]  mode;
        logic [31:0] exp_low;
        logic        exp_tag;
        int          d_lossy;
        int          d_tclr;
    } vec_t;

    vec_t vecs [NVEC];
    int checks = 0;
    int errors = 0;
    int exp_lossy = 0;
    int exp_tclr  = 0;
    logic [CAP_W-1:0] held_cap;
    logic [CAP_W-1:0] burst [8];

    task automatic chk(input string name, input logic [CAP_W-1:0] act, input logic [CAP_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_cap = '0; in_mode = 2'b00; out_ready = 1'b1; clr_stats = 1'b0;

        vecs[0] = '{1'b1, 96'hA5A5_A5A5_0123_4567_89AB_CDEF, 32'h1234_5FFF, 2'b01, 32'h1234_5C00, 1'b1, 1, 0};
        vecs[1] = '{1'b1, 96'h0000_0000_0000_0000_0000_0001, 32'h0000_0401, 2'b10, 32'h0000_0800, 1'b1, 1, 0};
        vecs[2] = '{1'b1, 96'hFFFF_0000_FFFF_0000_FFFF_0000, 32'h0000_0400, 2'b10, 32'h0000_0400, 1'b1, 0, 0};
        vecs[3] = '{1'b1, 96'hDEAD_BEEF_CAFE_F00D_1357_9BDF, 32'h1234_5FFF, 2'b00, 32'h1234_5FFF, 1'b1, 0, 0};
        vecs[4] = '{1'b1, 96'h1111_2222_3333_4444_5555_6666, 32'h1234_5FFF, 2'b11, 32'h1234_5FFF, 1'b1, 0, 0};
        vecs[5] = '{1'b1, 96'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F, 32'hFFFF_FC01, 2'b10, 32'hFFFF_FC00, 1'b0, 1, 1};
        vecs[6] = '{1'b0, 96'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F, 32'hFFFF_FC01, 2'b10, 32'hFFFF_FC00, 1'b0, 1, 0};
        vecs[7] = '{1'b0, 96'h8000_0000_0000_0000_0000_0000, 32'h0000_03FF, 2'b01, 32'h0000_0000, 1'b0, 1, 0};
        vecs[8] = '{1'b1, 96'h0000_0000_0000_0000_0000_00FF, 32'h8000_0001, 2'b10, 32'h8000_0400, 1'b1, 1, 0};
        vecs[9] = '{1'b1, 96'h7777_7777_7777_7777_7777_7777, 32'hFFFF_FBFF, 2'b10, 32'hFFFF_FC00, 1'b1, 1, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", CAP_W'(out_valid), '0);
        chk("reset_out_cap", out_cap, '0);
        chk("reset_lossy", CAP_W'(lossy_count), '0);
        chk("reset_tclr", CAP_W'(tag_clear_count), '0);
        chk("reset_in_ready", CAP_W'(in_ready), CAP_W'(1));
        @(negedge clk);
        rst = 1'b0;

        // Table-driven rounding vectors
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            in_cap   = {vecs[i].tag, vecs[i].upper, vecs[i].low};
            in_mode  = vecs[i].mode;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            exp_lossy = (exp_lossy + vecs[i].d_lossy > CNT_MAX) ? CNT_MAX : exp_lossy + vecs[i].d_lossy;
            exp_tclr  = (exp_tclr + vecs[i].d_tclr > CNT_MAX) ? CNT_MAX : exp_tclr + vecs[i].d_tclr;
            chk($sformatf("vec%0d_valid", i), CAP_W'(out_valid), CAP_W'(1));
            chk($sformatf("vec%0d_cap", i), out_cap, {vecs[i].exp_tag, vecs[i].upper, vecs[i].exp_low});
            chk($sformatf("vec%0d_lossy", i), CAP_W'(lossy_count), CAP_W'(exp_lossy));
            chk($sformatf("vec%0d_tclr", i), CAP_W'(tag_clear_count), CAP_W'(exp_tclr));
            @(negedge clk);
            in_valid = 1'b0;
        end

        // clr_stats coincident with a lossy accept
        @(negedge clk);
        in_cap = {1'b1, 96'h0, 32'h0000_0001}; in_mode = 2'b01; in_valid = 1'b1; clr_stats = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_lossy", CAP_W'(lossy_count), '0);
        chk("clr_tclr", CAP_W'(tag_clear_count), '0);
        chk("clr_out_cap", out_cap, {1'b1, 96'h0, 32'h0000_0000});
        @(negedge clk);
        clr_stats = 1'b0; in_valid = 1'b0;

        // Backpressure: three offered inputs, only the first is accepted
        @(negedge clk);
        out_ready = 1'b0; in_mode = 2'b00; in_valid = 1'b1;
        held_cap = {1'b1, 96'hABCD, 32'h0000_1111};
        in_cap = held_cap;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_valid", c), CAP_W'(out_valid), CAP_W'(1));
            chk($sformatf("bp%0d_cap", c), out_cap, held_cap);
            chk($sformatf("bp%0d_in_ready", c), CAP_W'(in_ready), '0);
            @(negedge clk);
            in_cap = {1'b0, 96'(c + 7), 32'(c * 3 + 5)};
        end

        // Release with 8 back-to-back inputs
        for (int k = 0; k < 8; k++) burst[k] = {k[0], 96'(k * 1000 + 1), 32'(32'hC0DE_0000 + k)};
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_cap = burst[k];
            @(posedge clk);
            #1;
            chk($sformatf("burst%0d_valid", k), CAP_W'(out_valid), CAP_W'(1));
            chk($sformatf("burst%0d_cap", k), out_cap, burst[k]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_valid", CAP_W'(out_valid), '0);
        chk("drain_hold_cap", out_cap, burst[7]);

        // Saturation: 20 tagged ceil overflows with 4-bit counters
        @(negedge clk);
        in_cap = {1'b1, 96'h5, 32'hFFFF_FC01}; in_mode = 2'b10; in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 14) begin
                chk("sat_lossy_at15", CAP_W'(lossy_count), CAP_W'(CNT_MAX));
            end
            @(negedge clk);
        end
        chk("sat_lossy", CAP_W'(lossy_count), CAP_W'(CNT_MAX));
        chk("sat_tclr", CAP_W'(tag_clear_count), CAP_W'(CNT_MAX));
        chk("sat_out_cap", out_cap, {1'b0, 96'h5, 32'hFFFF_FC00});

        // Asynchronous reset while a capability is held under backpressure
        out_ready = 1'b0;
        in_cap = {1'b1, 96'h9, 32'h0000_0123}; in_mode = 2'b01;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pre_rst_valid", CAP_W'(out_valid), CAP_W'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", CAP_W'(out_valid), '0);
        chk("arst_out_cap", out_cap, '0);
        chk("arst_lossy", CAP_W'(lossy_count), '0);
        chk("arst_tclr", CAP_W'(tag_clear_count), '0);
        chk("arst_in_ready", CAP_W'(in_ready), CAP_W'(1));

        // First accept right after deassertion
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        in_cap = {1'b1, 96'h3, 32'h0000_07FF}; in_mode = 2'b10; in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_cap", out_cap, {1'b1, 96'h3, 32'h0000_0800});
        chk("post_rst_lossy", CAP_W'(lossy_count), CAP_W'(1));
        @(negedge clk);
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cap_trunc_pipe.md
# cap_trunc_pipe

Pipelined, parametrised successor to the combinational capability mantissa compressor in the CHERI capability-width study datapath. Each transfer takes one tagged capability and reduces the precision of one bit field within it. The number of discarded low bits and the field position are set by parameters. The rounding mode is chosen per transfer. The block has a registered valid/ready stage, can invalidate a capability whose rounded field overflows by clearing its tag, and keeps saturating statistics counters for the CPI/width study.

## Interface
Parameters:
- CAP_W, 129: capability width including tag; the tag is bit CAP_W-1.
- FIELD_LSB, 0: LSB position of the compressed field within the payload.
- FIELD_W, 32: width of the compressed field.
- TRUNC_BITS, 10: low field bits discarded; legal range 1..FIELD_W-1.
- CNT_W, 32: statistics counter width.
- Legality: FIELD_LSB+FIELD_W <= CAP_W-1. An illegal configuration is an elaboration error.

Ports:
- clk, in, 1: clock. The block uses this single clock.
- rst, in, 1: reset, asynchronous and active-high.
- in_valid, in, 1: input capability valid.
- in_ready, out, 1: block can accept.
- in_cap, in, CAP_W: input capability.
- in_mode, in, 2: rounding mode, sampled with in_cap.
  - 00 = bypass
  - 01 = floor
  - 10 = ceil
  - 11 = reserved; behaves as bypass.
- out_valid, out, 1: output capability valid.
- out_ready, in, 1: downstream can accept.
- out_cap, out, CAP_W: compressed capability.
- clr_stats, in, 1: synchronous clear of both counters.
- lossy_count, out, CNT_W: accepted transfers in floor/ceil mode with nonzero discarded bits. Saturating.
- tag_clear_count, out, CNT_W: accepted transfers whose tag was cleared by ceil overflow. Saturating.

## Operation
Field handling. Let F = in_cap[FIELD_LSB +: FIELD_W] and L = F[TRUNC_BITS-1:0]. Bits outside F and the tag pass through unchanged, except for the tag rule below.

Per-mode result:
- Bypass: out = in, bit-exact.
- Floor: F' = F with L forced to 0. The tag is unchanged.
- Ceil, L == 0: F' = F. The tag is unchanged.
- Ceil, L != 0: compute H = F[FIELD_W-1:TRUNC_BITS] + 1 in FIELD_W-TRUNC_BITS+1 bits.
  - No carry out: F' = {H[FIELD_W-TRUNC_BITS-1:0], TRUNC_BITS'b0}. The tag is unchanged.
  - Carry out (H overflows the field): F' takes the floor result and the tag is forced to 0. The capability is unrepresentable and becomes invalid.

Counters:
- lossy_count increments on an accepted transfer when the mode is 01/10 and L != 0.
- tag_clear_count increments on an accepted transfer that hits the ceil-overflow case and has input tag 1. An input that already has tag 0 does not count.
- Both counters saturate at all-ones and do not wrap.
- clr_stats has priority. In a cycle with clr_stats=1, both counters load 0 and a coincident event is dropped.

Handshake and storage:
- Single output register stage.
- in_ready = !out_valid || out_ready. This is combinational, so there is no bubble under full throughput.
- Transfer in occurs when in_valid && in_ready. Transfer out occurs when out_valid && out_ready.
- While out_valid && !out_ready, out_cap is held stable and in_ready = 0.
- When no transfer is in but one completes out, out_valid falls to 0. out_cap holds its last value.
- in_cap and in_mode are don't-care while in_valid = 0.

## Timing
- Latency: 1 cycle. A capability accepted at edge N appears on out_cap with out_valid=1 after edge N.
- Throughput: 1 capability per cycle while out_ready=1.
- Counters update on the same edge as the accepting transfer.
- Reset, at any time including mid-transfer (asynchronous assertion):
  - out_valid=0, out_cap=0, lossy_count=0, tag_clear_count=0.
  - in_ready reads 1 during and after reset.
  - Any held capability is discarded.
- Deassertion is expected to be synchronous to clk, which is an integrator responsibility. The first accept can occur on the first edge after deassertion.
- in_ready, out_valid and out_cap have no combinational path from in_cap or in_mode.

## Test plan
Defaults apply: field = bits 31:0, TRUNC_BITS=10, tag = bit 128.
- Floor: tag=1, low32=0x1234_5FFF, mode 01 → next cycle low32=0x1234_5C00, tag=1, upper bits unchanged, lossy_count=1.
- Ceil: low32=0x0000_0401 → 0x0000_0800 with tag kept, lossy_count+1. Then low32=0x0000_0400 → 0x0000_0400 with the counter unchanged. Mode 00 and mode 11 with 0x1234_5FFF → bit-exact passthrough with no count.
- Ceil overflow: tag=1, low32=0xFFFF_FC01 → low32=0xFFFF_FC00, tag=0, tag_clear_count=1. Same input with tag=0 → tag_clear_count unchanged, lossy_count+1.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 and distinct data → one accept only, out_cap stable, in_ready=0. Then release with 8 back-to-back inputs → 8 outputs in order on consecutive cycles and no gaps.
- Reset mid-operation: assert rst asynchronously between edges while out_valid=1 and out_ready=0 → out_valid, out_cap and both counters read 0 immediately, and in_ready=1.
- Stats: clr_stats=1 in the same cycle as a lossy accept → lossy_count=0. With CNT_W=4, apply 20 lossy transfers → lossy_count stays at 15.
